// File: rtl/ram_param_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
// The clear-engine state encoding lives here so the controller and any future users agree on it.
package ram_param_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Range check done at 32 bits so non-power-of-two depths compare cleanly.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ram_param_if.sv
// Access port bundle for ram_param: request signals from the master, read/status back from the RAM.
interface ram_param_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
) ();

  logic             clear;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data_in;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             addr_err;
  logic             busy;

  modport master (
    output clear, addr, data_in, we, re,
    input  data_out, rd_valid, addr_err, busy
  );

  modport slave (
    input  clear, addr, data_in, we, re,
    output data_out, rd_valid, addr_err, busy
  );

endinterface

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks clr_ptr over every word once, writing the init value, after reset or on request.
module ram_clear_ctrl
  import ram_param_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // A clear request in either state restarts the sweep from word 0.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (clear) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/ram_param.sv
// Parametrised single-port synchronous RAM with registered read, range checking and a clear engine.
// The clear engine and the user port share one array write port; the clear port has priority.
module ram_param
  import ram_param_pkg::*;
#(
  parameter  int               WIDTH      = 16,
  parameter  int               DEPTH      = 64,
  parameter  logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int               AW         = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        reset,
  ram_param_if.slave bus
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic             busy;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             in_range;
  logic             accept;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  ram_clear_ctrl #(.DEPTH(DEPTH)) u_clear_ctrl (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign in_range = addr_in_range(32'(bus.addr), DEPTH);
  assign accept   = !busy;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.addr;
    wr_data = bus.data_in;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = INIT_VALUE;
    end else if (accept && bus.we && in_range) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-first: the read samples the array before this edge's write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
      bus.addr_err <= 1'b0;
    end else begin
      bus.rd_valid <= accept && bus.re;
      bus.addr_err <= accept && (bus.we || bus.re) && !in_range;
      if (accept && bus.re) begin
        bus.data_out <= in_range ? mem[bus.addr] : '0;
      end
    end
  end

  assign bus.busy = busy;

endmodule

// File: tb/tb_ram_param.sv
// Self-checking bench for ram_param: a 64x16 and a 40x8 instance against an array-level model.
module tb_ram_param;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  ram_param_if #(.WIDTH(16), .AW(6)) bus64 ();
  ram_param_if #(.WIDTH(8),  .AW(6)) bus40 ();

  ram_param #(.WIDTH(16), .DEPTH(64), .INIT_VALUE(16'h0000)) dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus64)
  );

  ram_param #(.WIDTH(8), .DEPTH(40), .INIT_VALUE(8'h3C)) dut40 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus40)
  );

  int assert_count = 0;
  int fail_count   = 0;

  logic [15:0] mem_m [2][64];
  int          clr_left  [2];
  logic [15:0] exp_dout  [2];
  logic        exp_valid [2];
  logic        exp_err   [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model view: a clear makes every word the init value at once and keeps the port busy for depth cycles.
  task automatic model_clear(input int d, input int depth, input logic [15:0] init);
    for (int i = 0; i < depth; i++) mem_m[d][i] = init;
    clr_left[d] = depth;
  endtask

  task automatic model_step(input int d, input int depth, input logic [15:0] init, input logic clr,
                            input logic we, input logic re, input int addr, input logic [15:0] din);
    exp_valid[d] = 1'b0;
    exp_err[d]   = 1'b0;
    if (clr_left[d] > 0) begin
      if (clr) clr_left[d] = depth;
      else     clr_left[d] = clr_left[d] - 1;
    end else begin
      exp_valid[d] = re;
      exp_err[d]   = (we || re) && (addr >= depth);
      if (re) exp_dout[d] = (addr < depth) ? mem_m[d][addr] : 16'h0000;
      if (we && addr < depth) mem_m[d][addr] = din;
      if (clr) model_clear(d, depth, init);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear(0, 64, 16'h0000);
      model_clear(1, 40, 16'h003C);
      for (int d = 0; d < 2; d++) begin
        exp_dout[d]  = '0;
        exp_valid[d] = 1'b0;
        exp_err[d]   = 1'b0;
      end
    end else begin
      model_step(0, 64, 16'h0000, bus64.clear, bus64.we, bus64.re, int'(bus64.addr), bus64.data_in);
      model_step(1, 40, 16'h003C, bus40.clear, bus40.we, bus40.re, int'(bus40.addr), {8'h00, bus40.data_in});
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("busy64",  32'(bus64.busy),     32'(clr_left[0] > 0));
      checkOutput("valid64", 32'(bus64.rd_valid), 32'(exp_valid[0]));
      checkOutput("err64",   32'(bus64.addr_err), 32'(exp_err[0]));
      checkOutput("dout64",  32'(bus64.data_out), 32'(exp_dout[0]));
      checkOutput("busy40",  32'(bus40.busy),     32'(clr_left[1] > 0));
      checkOutput("valid40", 32'(bus40.rd_valid), 32'(exp_valid[1]));
      checkOutput("err40",   32'(bus40.addr_err), 32'(exp_err[1]));
      checkOutput("dout40",  32'(bus40.data_out), 32'(exp_dout[1][7:0]));
    end
  end

  task automatic set_bus(input int d, input logic clr, input logic we, input logic re,
                         input int addr, input logic [15:0] din);
    if (d == 0) begin
      bus64.clear = clr; bus64.we = we; bus64.re = re;
      bus64.addr = 6'(addr); bus64.data_in = din;
    end else begin
      bus40.clear = clr; bus40.we = we; bus40.re = re;
      bus40.addr = 6'(addr); bus40.data_in = din[7:0];
    end
  endtask

  task automatic idle_all();
    set_bus(0, 1'b0, 1'b0, 1'b0, 0, 16'h0000);
    set_bus(1, 1'b0, 1'b0, 1'b0, 0, 16'h0000);
  endtask

  // One access cycle; returns just after the edge with the outputs of that access visible.
  task automatic applyStimulus(input int d, input logic clr, input logic we, input logic re,
                               input int addr, input logic [15:0] din);
    set_bus(d, clr, we, re, addr, din);
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic read_expect(input int d, input int addr, input logic [15:0] exp, input string name);
    applyStimulus(d, 1'b0, 1'b0, 1'b1, addr, 16'h0000);
    checkOutput({name, "_data"},  d == 0 ? 32'(bus64.data_out) : 32'(bus40.data_out), 32'(exp));
    checkOutput({name, "_valid"}, d == 0 ? 32'(bus64.rd_valid) : 32'(bus40.rd_valid), 32'd1);
  endtask

  // Counts busy cycles on both instances, bounded, and drops any pending inputs once both are idle.
  task automatic count_busy(output int c64, output int c40);
    c64 = 0;
    c40 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus64.busy) c64++;
      if (bus40.busy) c40++;
      if (!bus64.busy && !bus40.busy) break;
    end
    idle_all();
    @(posedge clk);
    #1;
  endtask

  int c64, c40;

  initial begin
    idle_all();
    reset = 1'b1;
    #1;
    checkOutput("reset_busy",  32'(bus64.busy),     32'd1);
    checkOutput("reset_valid", 32'(bus64.rd_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    count_busy(c64, c40);
    checkOutput("init_busy_cycles64", 32'(c64), 32'd64);
    checkOutput("init_busy_cycles40", 32'(c40), 32'd40);
    read_expect(0, 0,  16'h0000, "init_rd0");
    read_expect(0, 31, 16'h0000, "init_rd31");
    read_expect(0, 63, 16'h0000, "init_rd63");
    read_expect(1, 39, 16'h003C, "init40_rd39");

    applyStimulus(0, 1'b0, 1'b1, 1'b0, 0,  16'hAAAA);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1,  16'hF0F0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 63, 16'h5555);
    checkOutput("write_no_valid", 32'(bus64.rd_valid), 32'd0);
    read_expect(0, 0,  16'hAAAA, "wr_rd0");
    read_expect(0, 1,  16'hF0F0, "wr_rd1");
    read_expect(0, 63, 16'h5555, "wr_rd63");

    applyStimulus(0, 1'b0, 1'b1, 1'b0, 5, 16'hBEEF);
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 5, 16'h1234);
    checkOutput("rdfirst_old", 32'(bus64.data_out), 32'h0000BEEF);
    read_expect(0, 5, 16'h1234, "rdfirst_new");

    applyStimulus(0, 1'b1, 1'b1, 1'b1, 2, 16'hABCD);
    checkOutput("clr_access_valid", 32'(bus64.rd_valid), 32'd1);
    checkOutput("clr_access_busy",  32'(bus64.busy),     32'd1);
    set_bus(0, 1'b0, 1'b1, 1'b0, 0, 16'hFFFF);
    count_busy(c64, c40);
    checkOutput("clr_busy_cycles64", 32'(c64), 32'd64);
    checkOutput("clr_busy_cycles40", 32'(c40), 32'd0);
    read_expect(0, 0,  16'h0000, "clr_rd0");
    read_expect(0, 1,  16'h0000, "clr_rd1");
    read_expect(0, 2,  16'h0000, "clr_rd2");
    read_expect(0, 63, 16'h0000, "clr_rd63");

    applyStimulus(1, 1'b0, 1'b1, 1'b0, 5, 16'h00A5);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 45, 16'h0077);
    checkOutput("oor_wr_err",   32'(bus40.addr_err), 32'd1);
    checkOutput("oor_wr_valid", 32'(bus40.rd_valid), 32'd0);
    read_expect(1, 45, 16'h0000, "oor_rd45");
    checkOutput("oor_rd_err", 32'(bus40.addr_err), 32'd1);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 40, 16'h0011);
    checkOutput("oor_wr40_err", 32'(bus40.addr_err), 32'd1);
    read_expect(1, 5, 16'h00A5, "oor_rd5");
    checkOutput("inrange_err", 32'(bus40.addr_err), 32'd0);
    read_expect(1, 39, 16'h003C, "edge_rd39");

    applyStimulus(0, 1'b0, 1'b1, 1'b0, 7, 16'hCAFE);
    read_expect(0, 7, 16'hCAFE, "pre_rst_rd7");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 0, 16'h0000);
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midclr_rst_dout", 32'(bus64.data_out), 32'd0);
    checkOutput("midclr_rst_busy", 32'(bus64.busy),     32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    count_busy(c64, c40);
    checkOutput("rst_busy_cycles64", 32'(c64), 32'd64);
    checkOutput("rst_busy_cycles40", 32'(c40), 32'd40);
    read_expect(0, 7, 16'h0000, "post_rst_rd7");

    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        set_bus(d, $urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 63)), 16'($urandom));
      end
      @(posedge clk);
      #1;
    end
    idle_all();
    count_busy(c64, c40);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
